// File: rtl/bp_pkg.sv
// Shared types and helpers for the BHT/BTB branch predictor.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CtrStrongNt = 2'b00;
  localparam ctr_t CtrWeakNt   = 2'b01;
  localparam ctr_t CtrWeakT    = 2'b10;
  localparam ctr_t CtrStrongT  = 2'b11;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == CtrStrongT) ? c : c + 2'd1;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == CtrStrongNt) ? c : c - 2'd1;
  endfunction

  // Callers truncate the 32-bit result to their own index/tag width.
  function automatic logic [31:0] pc_idx(input logic [63:0] pc, input int unsigned idx_bits);
    return 32'((pc >> 2) & ((64'd1 << idx_bits) - 64'd1));
  endfunction

  function automatic logic [31:0] pc_tag(input logic [63:0] pc, input int unsigned idx_bits,
                                         input int unsigned tag_bits);
    return 32'((pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1));
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped tagged branch target buffer: combinational read, one write port, flush.
module bp_btb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  input  logic [TAG_BITS-1:0] rd_tag_i,
  output logic                hit_o,
  output logic [XLEN-1:0]     rd_target_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  logic [XLEN-1:0]     wr_target_i,
  input  logic                flush_i
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  logic                valid_q  [Entries];
  logic [TAG_BITS-1:0] tag_q    [Entries];
  logic [XLEN-1:0]     target_q [Entries];

  assign hit_o       = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_target_o = target_q[rd_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (flush_i) begin
      // Flush only drops valid bits; a write in the same cycle is discarded.
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i]  <= 1'b1;
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Fetch-stage predictor: 2-bit counter BHT plus tagged BTB, trained from execute.
// Optional gshare indexing of the BHT is enabled with `define BP_GSHARE_EN.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned GHR_BITS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_f,
  output logic            predict_taken_f,
  output logic [XLEN-1:0] predict_target_f,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_jump,
  input  logic [XLEN-1:0] upd_target,
  input  logic            flush_bp
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  logic [IDX_BITS-1:0] f_idx, u_idx, f_bht_idx, u_bht_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic                upd_dir;

  assign f_idx   = IDX_BITS'(pc_idx(64'(pc_f), IDX_BITS));
  assign u_idx   = IDX_BITS'(pc_idx(64'(upd_pc), IDX_BITS));
  assign f_tag   = TAG_BITS'(pc_tag(64'(pc_f), IDX_BITS, TAG_BITS));
  assign u_tag   = TAG_BITS'(pc_tag(64'(upd_pc), IDX_BITS, TAG_BITS));
  assign upd_dir = upd_taken | upd_jump;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  assign ghr_d     = GHR_BITS'({ghr_q, upd_dir});
  assign f_bht_idx = f_idx ^ IDX_BITS'(ghr_q);
  assign u_bht_idx = u_idx ^ IDX_BITS'(ghr_q);

  // Non-speculative history: only resolved outcomes shift in; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign f_bht_idx = f_idx;
  assign u_bht_idx = u_idx;
`endif

  ctr_t ctr_q [Entries];
  ctr_t ctr_d;

  always_comb begin
    ctr_d = ctr_q[u_bht_idx];
    if (upd_jump) begin
      ctr_d = CtrStrongT;
    end else if (upd_taken) begin
      ctr_d = sat_inc(ctr_q[u_bht_idx]);
    end else begin
      ctr_d = sat_dec(ctr_q[u_bht_idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= CtrWeakNt;
      end
    end else if (upd_valid) begin
      ctr_q[u_bht_idx] <= ctr_d;
    end
  end

  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

  bp_btb #(
    .XLEN     (XLEN),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (f_idx),
    .rd_tag_i    (f_tag),
    .hit_o       (btb_hit),
    .rd_target_o (btb_target),
    .wr_en_i     (upd_valid && upd_dir && !flush_bp),
    .wr_idx_i    (u_idx),
    .wr_tag_i    (u_tag),
    .wr_target_i (upd_target),
    .flush_i     (flush_bp)
  );

  assign predict_taken_f  = btb_hit && ctr_q[f_bht_idx][1];
  assign predict_target_f = predict_taken_f ? btb_target : '0;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht (default build, gshare disabled).
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        predict_taken_f;
  logic [31:0] predict_target_f;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_jump;
  logic [31:0] upd_target;
  logic        flush_bp;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_f             (pc_f),
    .predict_taken_f  (predict_taken_f),
    .predict_target_f (predict_target_f),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_jump         (upd_jump),
    .upd_target       (upd_target),
    .flush_bp         (flush_bp)
  );

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (predict_taken_f !== e.taken || predict_target_f !== e.target) begin
        n_fail++;
        $display("FAIL %s: got taken=%0b target=0x%08h, expected taken=%0b target=0x%08h",
                 e.name, predict_taken_f, predict_target_f, e.taken, e.target);
      end
    end
  end

  // Drive one cycle of inputs just after the edge; expectation is for that same cycle.
  task automatic step(input string nm, input logic rn, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut, input logic uj,
                      input logic [31:0] utgt, input logic fl,
                      input logic et, input logic [31:0] etgt);
    @(posedge clk);
    #1;
    rst_n      = rn;
    pc_f       = pc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_jump   = uj;
    upd_target = utgt;
    flush_bp   = fl;
    sb.push_back('{nm, et, etgt});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_f = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_jump = 1'b0; upd_target = '0; flush_bp = 1'b0;
    repeat (3) @(posedge clk);

    //    name          rn   pc      uv   upc     ut   uj   utgt    fl   et   etgt
    step("reset",       1, 32'h100, 0, 32'h0,   0, 0, 32'h0,  0, 0, 32'h0);
    step("tk1_pre",     1, 32'h100, 1, 32'h100, 1, 0, 32'h40, 0, 0, 32'h0);
    step("tk2_pre",     1, 32'h100, 1, 32'h100, 1, 0, 32'h40, 0, 1, 32'h40);
    step("ctr11",       1, 32'h100, 1, 32'h100, 0, 0, 32'h0,  0, 1, 32'h40);
    step("ctr10",       1, 32'h100, 1, 32'h100, 0, 0, 32'h0,  0, 1, 32'h40);
    step("ctr01",       1, 32'h100, 1, 32'h100, 0, 0, 32'h0,  0, 0, 32'h0);
    step("ctr00",       1, 32'h100, 1, 32'h100, 0, 0, 32'h0,  0, 0, 32'h0);
    step("ctr00_sat",   1, 32'h100, 1, 32'h100, 1, 0, 32'h40, 0, 0, 32'h0);
    step("ctr01_nt",    1, 32'h100, 1, 32'h100, 1, 0, 32'h40, 0, 0, 32'h0);
    step("ctr10_tk",    1, 32'h104, 0, 32'h0,   0, 0, 32'h0,  0, 0, 32'h0);
    step("ctr10_tk2",   1, 32'h100, 0, 32'h0,   0, 0, 32'h0,  0, 1, 32'h40);
    step("jmp_pre",     1, 32'h200, 1, 32'h200, 0, 1, 32'h80, 0, 0, 32'h0);
    step("jmp_hit",     1, 32'h200, 0, 32'h0,   0, 0, 32'h0,  0, 1, 32'h80);
    step("alias_miss",  1, 32'h300, 0, 32'h0,   0, 0, 32'h0,  0, 0, 32'h0);
    step("tag_replace", 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,  0, 0, 32'h0);
    step("same_cyc",    1, 32'h300, 1, 32'h300, 1, 0, 32'h180,0, 0, 32'h0);
    step("next_cyc",    1, 32'h300, 0, 32'h0,   0, 0, 32'h0,  0, 1, 32'h180);
    step("flush_pre",   1, 32'h300, 1, 32'h100, 1, 0, 32'h40, 1, 1, 32'h180);
    step("flushed_300", 1, 32'h300, 0, 32'h0,   0, 0, 32'h0,  0, 0, 32'h0);
    step("flushed_100", 1, 32'h100, 1, 32'h100, 1, 0, 32'h40, 0, 0, 32'h0);
    step("realloc",     1, 32'h100, 0, 32'h0,   0, 0, 32'h0,  0, 1, 32'h40);
    step("rst_async",   0, 32'h100, 1, 32'h100, 1, 0, 32'h40, 0, 0, 32'h0);
    step("post_rst",    1, 32'h100, 1, 32'h100, 1, 0, 32'h40, 0, 0, 32'h0);
    step("post_rst_tk", 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,  0, 1, 32'h40);

    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush_bp  = 1'b0;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
